// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the multiply/divide sequencer.
// Divider support is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    FIX,
    DONE
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  function automatic logic [31:0] mag(
    input logic [31:0] v
  );
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: start/operand request and HI/LO result bundle.
// master is the main control unit, slave is the sequencer.
interface muldiv_if;

  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start_mult,
    output start_div,
    output op_a,
    output op_b,
    input  busy,
    input  done,
    input  div_zero,
    input  hi,
    input  lo
  );

  modport slave (
    input  start_mult,
    input  start_div,
    input  op_a,
    input  op_b,
    output busy,
    output done,
    output div_zero,
    output hi,
    output lo
  );

endinterface

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one restoring-division step on unsigned magnitudes.
// Used by muldiv_seq only when MULDIV_DIV_EN is defined.
module muldiv_div_step (
  input  logic [31:0] part_rem,
  input  logic        dbit,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        q_bit
);

  logic [32:0] shifted;
  logic [32:0] diff;

  assign shifted = {part_rem, dbit};
  assign diff    = shifted - {1'b0, divisor};

  // part_rem < divisor, so a clear borrow means the subtract fits
  assign q_bit    = ~diff[32];
  assign rem_next = q_bit ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed multiply/divide sequencer owning HI/LO.
// Define MULDIV_DIV_EN to build the divider path and DIV state.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  op_t              op_q;
  logic             sa_q;
  logic             sb_q;
  logic             dz_q;
  logic [31:0]      mag_q;
  logic [31:0]      wh_q;
  logic [31:0]      wl_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic        ready;
  logic        acc_mult;
  logic        acc_div;
  logic        div_by0;
  logic        last;
  logic [32:0] msum;
  logic [63:0] prod;
  logic [63:0] prod_fix;
  logic [31:0] hi_fix;
  logic [31:0] lo_fix;

  assign ready = (state_q == IDLE)
              || (state_q == DONE);

  assign acc_mult = ready && bus.start_mult;

`ifdef MULDIV_DIV_EN
  assign acc_div = ready
                && bus.start_div
                && !bus.start_mult;
`else
  logic unused_div;
  assign unused_div = bus.start_div;
  assign acc_div    = 1'b0;
`endif

  assign div_by0 = acc_div
                && (bus.op_b == 32'd0);

  assign last = (cnt_q == CNT_W'(ITER - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (acc_mult)
          state_d = MULT;
        else if (acc_div)
          state_d = div_by0 ? DONE : DIV;
      end
      MULT: if (last) state_d = FIX;
`ifdef MULDIV_DIV_EN
      DIV:  if (last) state_d = FIX;
`endif
      FIX:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // shift-add: wh is the accumulator, wl the
  // multiplier draining into the product low half
  assign msum = {1'b0, wh_q}
              + (wl_q[0] ? {1'b0, mag_q} : 33'd0);

`ifdef MULDIV_DIV_EN
  logic [31:0] d_rem;
  logic        d_bit;

  muldiv_div_step u_step (
    .part_rem (wh_q),
    .dbit     (wl_q[31]),
    .divisor  (mag_q),
    .rem_next (d_rem),
    .q_bit    (d_bit)
  );
`endif

  assign prod     = {wh_q, wl_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;

  always_comb begin
    hi_fix = prod_fix[63:32];
    lo_fix = prod_fix[31:0];
    if (op_q == OP_DIV) begin
      hi_fix = sa_q ? -wh_q : wh_q;
      lo_fix = (sa_q ^ sb_q) ? -wl_q : wl_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= OP_MULT;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      dz_q  <= 1'b0;
      mag_q <= '0;
      wh_q  <= '0;
      wl_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (acc_mult || acc_div) begin
      cnt_q <= '0;
      op_q  <= acc_mult ? OP_MULT : OP_DIV;
      sa_q  <= bus.op_a[31];
      sb_q  <= bus.op_b[31];
      dz_q  <= div_by0;
      wh_q  <= '0;
      if (acc_mult) begin
        mag_q <= mag(bus.op_a);
        wl_q  <= mag(bus.op_b);
      end else begin
        mag_q <= mag(bus.op_b);
        wl_q  <= mag(bus.op_a);
      end
    end else if (state_q == MULT) begin
      cnt_q <= cnt_q + CNT_W'(1);
      wh_q  <= msum[32:1];
      wl_q  <= {msum[0], wl_q[31:1]};
    end
`ifdef MULDIV_DIV_EN
    else if (state_q == DIV) begin
      cnt_q <= cnt_q + CNT_W'(1);
      wh_q  <= d_rem;
      wl_q  <= {wl_q[30:0], d_bit};
    end
`endif
    else if (state_q == FIX) begin
      hi_q <= hi_fix;
      lo_q <= lo_fix;
    end
  end

  assign bus.busy = (state_q == MULT)
                 || (state_q == DIV)
                 || (state_q == FIX);

  assign bus.done     = (state_q == DONE);
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
